id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode stage plus ID/EX pipeline register of the MIPS datapath; sits directly upstream of the register bank.
//  - Splits the IF/ID instruction and drives rs/rt and the active-low read flag to the bank.
//  - Latches the returned dato_A/dato_B, sign/zero-extended immediate and control bits for EX.
//  - Detects load-use hazards against its own registered EX-side instruction, inserts bubbles, honours flush and EX backpressure.
// PARAMETERS
//  (none; widths fixed at 32-bit data, 5-bit register index)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   asynchronous, active-high reset
//  in_valid       in   1   IF/ID holds a valid instruction
//  in_ready       out  1   instruction accepted this cycle
//  in_instr       in   32  instruction word
//  in_pc4         in   32  PC+4 of instruction
//  flush          in   1   branch/jump taken: squash instruction being decoded
//  ex_ready       in   1   EX can accept; low = hold ID/EX
//  rs, rt         out  5   register-bank read addresses (= in_instr[25:21], [20:16])
//  read_reg_flag  out  1   active-low bank read enable = ~in_valid
//  dato_A, dato_B in   32  bank read data (combinational)
//  wb_write_flag  in   1   active-low writeback strobe (same as bank write flag)
//  wb_reg         in   5   writeback destination
//  wb_data        in   32  writeback data
//  out_valid      out  1   ID/EX holds a valid instruction
//  out_pc4, out_A, out_B, out_imm  out 32  latched PC+4, operands, extended immediate
//  out_rs, out_rt, out_rd          out 5   source regs; destination (rd for opcode 0, else rt)
//  out_opcode, out_funct           out 6   instruction fields
//  out_shamt                       out 5   shift amount
//  out_mem_read, out_mem_write, out_reg_write  out 1  control bits
// BEHAVIOUR
//  - Reset (async): every output register 0, out_valid 0; takes effect immediately, mid-stall or mid-flush included.
//  - Latency: one cycle from acceptance to out_valid.
//  - uses_rt: opcode in {0x00, 0x2B, 0x04, 0x05}.
//  - hazard = in_valid & out_valid & out_mem_read & out_rd!=0 & (out_rd==rs | (uses_rt & out_rd==rt)).
//  - in_ready = flush | (ex_ready & ~hazard).
//  - Posedge priority, highest first:
//    1. flush: bubble.
//    2. ~ex_ready: hold all of ID/EX.
//    3. hazard: bubble; IF/ID held because in_ready=0.
//    4. otherwise: capture, out_valid<=in_valid.
//  - Bubble: out_valid=0; mem_read/mem_write/reg_write=0; other fields don't-care.
//  - Hazard stall lasts exactly one cycle; the bubble clears out_mem_read, so the next cycle issues.
//  - Imm: zero-extend for opcode 0x0C/0x0D/0x0E, sign-extend otherwise.
//  - Control decode:
//    0x00 reg_write; 0x23 mem_read+reg_write; 0x2B mem_write;
//    0x08/0x0A/0x0C/0x0D/0x0E/0x0F reg_write; everything else all 0.
// CONFIGURATION
//  - WB_BYPASS_EN defined:
//    if ~wb_write_flag & wb_reg!=0 & wb_reg==rs, capture wb_data into out_A instead of dato_A; same for rt/out_B.
//  - WB_BYPASS_EN undefined: dato_A/dato_B captured unmodified.
// STRUCTURE
//  - Package mips_pkg: opcode/funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, ...) and the control-bit bundle.
//  - Sub-module control_decoder (combinational): opcode -> mem_read/mem_write/reg_write, uses_rt, zero_ext.
// TESTING
//  - Reset pulse while out_valid=1 -> all outputs 0 same cycle, before any clk edge.
//  - add $t2,$t0,$t1 (0x01095020), dato_A=5, dato_B=7 -> next cycle:
//    out_valid=1, out_A=5, out_B=7, out_rd=10, out_reg_write=1.
//  - lw $t0,4($t3) (0x8D680004) then add using $t0:
//    in_ready=0 one cycle, one bubble (out_valid=0), add issues the following cycle.
//  - flush=1 with in_valid=1 -> in_ready=1, out_valid=0 next cycle, control bits 0.
//  - ex_ready=0 for 3 cycles -> all ID/EX outputs stable, in_ready=0;
//    resumes capture on first cycle ex_ready=1.
//  - wb_write_flag=0, wb_reg=8, wb_data=0xDEADBEEF, rs=8, dato_A=0:
//    out_A=0xDEADBEEF with WB_BYPASS_EN, 0 without; wb_reg=0 is never bypassed.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes and the control-bit bundle.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function codes (instr[5:0]) for R-type
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Control bits carried into EX
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } ctrl_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode decoder: control bits, rt-as-source flag, immediate extension mode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow the opcode input.
// Ports: opcode (6) in; ctrl (mem_read/mem_write/reg_write), uses_rt, zero_ext out.
module control_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       uses_rt,
  output logic       zero_ext
);

  always_comb begin
    ctrl     = '0;
    uses_rt  = 1'b0;
    zero_ext = 1'b0;

    case (opcode)
      OP_RTYPE: ctrl.reg_write = 1'b1;
      OP_LW: begin
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_SW:    ctrl.mem_write = 1'b1;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                ctrl.reg_write = 1'b1;
      default:  ctrl = '0;
    endcase

    // rt is read as a source operand (not a destination) for these
    uses_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);

    // Logical immediates are zero-extended
    zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  end

endmodule

// File: rtl/id_ex_stage.sv
// MIPS decode stage + ID/EX pipeline register with load-use bubble, flush and EX hold.
// Latency: 1 cycle from acceptance (in_valid & in_ready) to out_valid.
// Backpressure: ex_ready low holds ID/EX and drops in_ready; load-use hazard drops in_ready one cycle.
// Ports: clk, reset (async active-high); IF/ID in_valid/in_ready/in_instr/in_pc4; flush; ex_ready;
//        bank side rs/rt/read_reg_flag (active-low), dato_A/dato_B; writeback wb_write_flag (active-low)/wb_reg/wb_data;
//        ID/EX out_valid, out_pc4/out_A/out_B/out_imm, out_rs/out_rt/out_rd, out_opcode/out_funct/out_shamt,
//        out_mem_read/out_mem_write/out_reg_write.
// Option: define WB_BYPASS_EN to forward same-cycle writeback data into out_A/out_B.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  input  logic        flush,
  input  logic        ex_ready,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        read_reg_flag,
  input  logic [31:0] dato_A,
  input  logic [31:0] dato_B,
  input  logic        wb_write_flag,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  output logic [31:0] out_pc4,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [5:0]  out_opcode,
  output logic [5:0]  out_funct,
  output logic [4:0]  out_shamt,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_reg_write
);

  logic [5:0]  opcode;
  logic [4:0]  rd_field;
  logic [4:0]  dest;
  logic [31:0] imm_ext;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  ctrl_t       ctrl;
  logic        uses_rt;
  logic        zero_ext;
  logic        hazard;

  assign opcode        = in_instr[31:26];
  assign rs            = in_instr[25:21];
  assign rt            = in_instr[20:16];
  assign rd_field      = in_instr[15:11];
  assign read_reg_flag = ~in_valid;

  control_decoder u_dec (
    .opcode   (opcode),
    .ctrl     (ctrl),
    .uses_rt  (uses_rt),
    .zero_ext (zero_ext)
  );

  assign dest    = (opcode == OP_RTYPE) ? rd_field : rt;
  assign imm_ext = zero_ext ? {16'h0000, in_instr[15:0]}
                            : {{16{in_instr[15]}}, in_instr[15:0]};

`ifdef WB_BYPASS_EN
  // Bank read and writeback land in the same cycle: take the value being written
  assign opnd_a = (!wb_write_flag && wb_reg != 5'd0 && wb_reg == rs) ? wb_data : dato_A;
  assign opnd_b = (!wb_write_flag && wb_reg != 5'd0 && wb_reg == rt) ? wb_data : dato_B;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_write_flag, wb_reg, wb_data};
  assign opnd_a    = dato_A;
  assign opnd_b    = dato_B;
`endif

  // Load in EX whose result the decoding instruction needs: one bubble suffices,
  // because the bubble clears out_mem_read and the hazard disappears next cycle.
  assign hazard = in_valid && out_valid && out_mem_read && (out_rd != 5'd0) &&
                  ((out_rd == rs) || (uses_rt && (out_rd == rt)));

  assign in_ready = flush || (ex_ready && !hazard);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_pc4       <= '0;
      out_A         <= '0;
      out_B         <= '0;
      out_imm       <= '0;
      out_rs        <= '0;
      out_rt        <= '0;
      out_rd        <= '0;
      out_opcode    <= '0;
      out_funct     <= '0;
      out_shamt     <= '0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_reg_write <= 1'b0;
    end else if (flush || (ex_ready && hazard)) begin
      // Bubble: only validity and side-effecting control bits matter
      out_valid     <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_reg_write <= 1'b0;
    end else if (ex_ready) begin
      out_valid     <= in_valid;
      out_pc4       <= in_pc4;
      out_A         <= opnd_a;
      out_B         <= opnd_b;
      out_imm       <= imm_ext;
      out_rs        <= rs;
      out_rt        <= rt;
      out_rd        <= dest;
      out_opcode    <= opcode;
      out_funct     <= in_instr[5:0];
      out_shamt     <= in_instr[10:6];
      out_mem_read  <= ctrl.mem_read  & in_valid;
      out_mem_write <= ctrl.mem_write & in_valid;
      out_reg_write <= ctrl.reg_write & in_valid;
    end
    // ex_ready low without flush: hold every ID/EX register
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, load-use bubble, flush, EX hold, bypass.
// Latency: checks ID/EX outputs 1 ns after each capturing clock edge.
// Backpressure: drives ex_ready low for three cycles and checks the hold.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        flush;
  logic        ex_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        read_reg_flag;
  logic [31:0] dato_A;
  logic [31:0] dato_B;
  logic        wb_write_flag;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid;
  logic [31:0] out_pc4;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic [31:0] out_imm;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [5:0]  out_opcode;
  logic [5:0]  out_funct;
  logic [4:0]  out_shamt;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_reg_write;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc4        (in_pc4),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .rs            (rs),
    .rt            (rt),
    .read_reg_flag (read_reg_flag),
    .dato_A        (dato_A),
    .dato_B        (dato_B),
    .wb_write_flag (wb_write_flag),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_pc4       (out_pc4),
    .out_A         (out_A),
    .out_B         (out_B),
    .out_imm       (out_imm),
    .out_rs        (out_rs),
    .out_rt        (out_rt),
    .out_rd        (out_rd),
    .out_opcode    (out_opcode),
    .out_funct     (out_funct),
    .out_shamt     (out_shamt),
    .out_mem_read  (out_mem_read),
    .out_mem_write (out_mem_write),
    .out_reg_write (out_reg_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " pc4"},   out_pc4, 32'd0);
    chk({tag, " A"},     out_A, 32'd0);
    chk({tag, " B"},     out_B, 32'd0);
    chk({tag, " imm"},   out_imm, 32'd0);
    chk({tag, " regs"},  {17'd0, out_rs, out_rt, out_rd}, 32'd0);
    chk({tag, " fields"}, {15'd0, out_opcode, out_funct, out_shamt}, 32'd0);
    chk({tag, " ctrl"},  {29'd0, out_mem_read, out_mem_write, out_reg_write}, 32'd0);
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc4,
                         input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc4   = pc4;
    dato_A   = a;
    dato_B   = b;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc4 = '0; flush = 1'b0;
    ex_ready = 1'b1; dato_A = '0; dato_B = '0;
    wb_write_flag = 1'b1; wb_reg = '0; wb_data = '0;
    #12;
    chk_all_zero("reset");
    chk("rdflag idle", {31'd0, read_reg_flag}, 32'd1);
    reset = 1'b0;
    tick();
    chk("idle valid", {31'd0, out_valid}, 32'd0);

    // add $t2,$t0,$t1
    present(32'h01095020, 32'h0000_0104, 32'd5, 32'd7);
    #1;
    chk("add rs/rt", {22'd0, rs, rt}, {22'd0, 5'd8, 5'd9});
    chk("add rdflag", {31'd0, read_reg_flag}, 32'd0);
    chk("add in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("add valid", {31'd0, out_valid}, 32'd1);
    chk("add A", out_A, 32'd5);
    chk("add B", out_B, 32'd7);
    chk("add rd", {27'd0, out_rd}, 32'd10);
    chk("add ctrl", {29'd0, out_mem_read, out_mem_write, out_reg_write}, 32'b001);
    chk("add funct", {26'd0, out_funct}, 32'h20);
    chk("add pc4", out_pc4, 32'h0000_0104);

    // Asynchronous reset mid-cycle while out_valid=1
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    #1 reset = 1'b0;
    in_valid = 1'b0;
    tick();

    // lw $t0,4($t3) followed by add using $t0
    present(32'h8D680004, 32'h0000_0200, 32'd0, 32'd0);
    tick();
    chk("lw valid", {31'd0, out_valid}, 32'd1);
    chk("lw ctrl", {29'd0, out_mem_read, out_mem_write, out_reg_write}, 32'b101);
    chk("lw rd", {27'd0, out_rd}, 32'd8);
    chk("lw imm", out_imm, 32'd4);
    present(32'h01095020, 32'h0000_0204, 32'd3, 32'd4);
    #1;
    chk("hazard in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bubble valid", {31'd0, out_valid}, 32'd0);
    chk("bubble mem_read", {31'd0, out_mem_read}, 32'd0);
    chk("post-bubble in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("add issue valid", {31'd0, out_valid}, 32'd1);
    chk("add issue rd", {27'd0, out_rd}, 32'd10);
    chk("add issue pc4", out_pc4, 32'h0000_0204);

    // Flush squashes sw being decoded
    present(32'hAD090008, 32'h0000_0208, 32'd1, 32'd2);
    flush = 1'b1;
    #1;
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    flush = 1'b0;
    chk("flush valid", {31'd0, out_valid}, 32'd0);
    chk("flush ctrl", {29'd0, out_mem_read, out_mem_write, out_reg_write}, 32'b000);

    // ori $t0,$t1,0xFFFF: zero-extended immediate, rd = rt
    present(32'h3528FFFF, 32'h0000_0300, 32'd0, 32'd0);
    tick();
    chk("ori imm", out_imm, 32'h0000FFFF);
    chk("ori rd", {27'd0, out_rd}, 32'd8);
    chk("ori ctrl", {29'd0, out_mem_read, out_mem_write, out_reg_write}, 32'b001);

    // addi $t1,$t2,-1 held back by ex_ready=0 for 3 cycles
    present(32'h2149FFFF, 32'h0000_0304, 32'd0, 32'd0);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d in_ready", i), {31'd0, in_ready}, 32'd0);
      tick();
      chk($sformatf("stall%0d hold", i), {out_imm[15:0], 10'd0, out_valid, out_rd}, {16'hFFFF, 10'd0, 1'b1, 5'd8});
      chk($sformatf("stall%0d pc4", i), out_pc4, 32'h0000_0300);
    end
    ex_ready = 1'b1;
    tick();
    chk("addi imm", out_imm, 32'hFFFFFFFF);
    chk("addi rd", {27'd0, out_rd}, 32'd9);
    chk("addi pc4", out_pc4, 32'h0000_0304);

    // sw $t1,8($t0): memory write only, sign-extended positive imm
    present(32'hAD090008, 32'h0000_0308, 32'd0, 32'd0);
    tick();
    chk("sw ctrl", {29'd0, out_mem_read, out_mem_write, out_reg_write}, 32'b010);
    chk("sw imm", out_imm, 32'd8);

    // Writeback bypass of rs=8
    present(32'h01095020, 32'h0000_0400, 32'd0, 32'd7);
    wb_write_flag = 1'b0; wb_reg = 5'd8; wb_data = 32'hDEADBEEF;
    tick();
`ifdef WB_BYPASS_EN
    chk("bypass A", out_A, 32'hDEADBEEF);
`else
    chk("bypass A", out_A, 32'd0);
`endif
    chk("bypass B untouched", out_B, 32'd7);

    // wb_reg=0 never bypassed: add $t2,$zero,$t1
    present(32'h00095020, 32'h0000_0404, 32'h11, 32'h22);
    wb_reg = 5'd0;
    tick();
    chk("no bypass r0", out_A, 32'h11);
    wb_write_flag = 1'b1;

    // Idle input produces an invalid slot
    in_valid = 1'b0;
    #1;
    chk("idle rdflag", {31'd0, read_reg_flag}, 32'd1);
    tick();
    chk("idle out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle ctrl", {29'd0, out_mem_read, out_mem_write, out_reg_write}, 32'b000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
